// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: CMD17/CMD24 with CRC7 command check, 64-bit blocks,
// CRC16-CCITT on data, data-response token and busy signalling on writes.
`timescale 1ns/1ps
module sd_spi_card_model #(
  parameter int ADDR_W      = 4,
  parameter int RESP_DELAY  = 2,
  parameter int READ_DELAY  = 4,
  parameter int DRESP_DELAY = 1,
  parameter int BUSY_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mosi,
  output logic              miso,
  input  logic              pl_en,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [63:0]       pl_data,
  output logic              busy,
  output logic [7:0]        last_r1
);

  // state         | meaning
  // S_IDLE        | waiting for start bit, preload allowed
  // S_CMD         | shifting in the remaining 47 command bits
  // S_RESP_WAIT   | delay before R1
  // S_RESP        | sending R1
  // S_W_TOKEN     | waiting for the 0 that ends start token FE
  // S_W_DATA      | receiving 64 data + 16 CRC bits
  // S_W_DRESP_WAIT| delay before data response
  // S_W_DRESP     | sending data response
  // S_W_BUSY      | holding miso low
  // S_R_WAIT      | idle-high gap before read token
  // S_R_TOKEN     | sending FE
  // S_R_DATA      | sending 64 data + 16 CRC bits
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_RESP_WAIT, S_RESP,
    S_W_TOKEN, S_W_DATA, S_W_DRESP_WAIT, S_W_DRESP, S_W_BUSY,
    S_R_WAIT, S_R_TOKEN, S_R_DATA
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [6:0] RESP_M1  = 7'(RESP_DELAY - 1);
  localparam logic [6:0] READ_M1  = 7'(READ_DELAY - 1);
  localparam logic [6:0] DRESP_M1 = 7'(DRESP_DELAY - 1);
  localparam logic [6:0] BUSY_M1  = 7'(BUSY_CYCLES - 1);

  state_t            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [63:0]       sh_q, sh_d;
  logic [6:0]        crc7_q, crc7_d;
  logic [15:0]       crc16_q, crc16_d;
  logic [15:0]       rx_crc_q, rx_crc_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        r1_q, r1_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              miso_q, miso_d;

  logic [63:0]       mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [63:0]       mem_wd;

  logic [5:0]        cmd_w;
  logic [31:0]       arg_w;
  logic [6:0]        crc_rx_w;
  logic [7:0]        r1_w;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    crc7_step = {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // At the end-bit edge sh_q holds frame bits 1..46, frame bit k at sh_q[46-k].
  assign cmd_w    = sh_q[44:39];
  assign arg_w    = sh_q[38:7];
  assign crc_rx_w = sh_q[6:0];

  always_comb begin
    r1_w = 8'h00;
    if ((crc7_q != crc_rx_w) || !mosi)         r1_w = 8'h08;
    else if (cmd_w != 6'd17 && cmd_w != 6'd24) r1_w = 8'h04;
    else if ((arg_w >> ADDR_W) != 32'd0)       r1_w = 8'h40;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    crc7_d   = crc7_q;
    crc16_d  = crc16_q;
    rx_crc_d = rx_crc_q;
    tx_d     = tx_q;
    r1_d     = r1_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    miso_d   = miso_q;
    mem_we   = 1'b0;
    mem_wa   = pl_addr;
    mem_wd   = pl_data;
    case (state_q)
      S_IDLE: begin
        mem_we = pl_en;
        if (!mosi) begin
          state_d = S_CMD;
          cnt_d   = 7'd46;
          crc7_d  = 7'd0;
        end
      end
      S_CMD: begin
        sh_d = {sh_q[62:0], mosi};
        if (cnt_q >= 7'd8) crc7_d = crc7_step(crc7_q, mosi);
        if (cnt_q == 7'd0) begin
          r1_d    = r1_w;
          tx_d    = r1_w;
          wr_d    = (cmd_w == 6'd24);
          addr_d  = arg_w[ADDR_W-1:0];
          state_d = S_RESP_WAIT;
          cnt_d   = RESP_M1;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_RESP_WAIT: begin
        if (cnt_q == 7'd0) begin
          miso_d  = tx_q[7];
          tx_d    = {tx_q[6:0], 1'b1};
          cnt_d   = 7'd7;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_RESP: begin
        if (cnt_q != 7'd0) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b1};
          cnt_d  = cnt_q - 7'd1;
        end else begin
          miso_d = 1'b1;
          if (r1_q != 8'h00) begin
            state_d = S_IDLE;
          end else if (wr_q) begin
            state_d = S_W_TOKEN;
          end else begin
            state_d = S_R_WAIT;
            cnt_d   = READ_M1;
            sh_d    = mem[addr_q];
            crc16_d = 16'd0;
          end
        end
      end
      S_W_TOKEN: begin
        if (!mosi) begin
          state_d = S_W_DATA;
          cnt_d   = 7'd79;
          crc16_d = 16'd0;
        end
      end
      S_W_DATA: begin
        if (cnt_q >= 7'd16) begin
          sh_d    = {sh_q[62:0], mosi};
          crc16_d = crc16_step(crc16_q, mosi);
        end else begin
          rx_crc_d = {rx_crc_q[14:0], mosi};
        end
        if (cnt_q == 7'd0) begin
          tx_d    = (crc16_q == {rx_crc_q[14:0], mosi}) ? 8'h05 : 8'h0B;
          state_d = S_W_DRESP_WAIT;
          cnt_d   = DRESP_M1;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_W_DRESP_WAIT: begin
        if (cnt_q == 7'd0) begin
          mem_we  = (tx_q == 8'h05);
          mem_wa  = addr_q;
          mem_wd  = sh_q;
          miso_d  = tx_q[7];
          tx_d    = {tx_q[6:0], 1'b1};
          cnt_d   = 7'd7;
          state_d = S_W_DRESP;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_W_DRESP: begin
        if (cnt_q != 7'd0) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b1};
          cnt_d  = cnt_q - 7'd1;
        end else begin
          miso_d  = 1'b0;
          cnt_d   = BUSY_M1;
          state_d = S_W_BUSY;
        end
      end
      S_W_BUSY: begin
        if (cnt_q == 7'd0) begin
          miso_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_R_WAIT: begin
        if (cnt_q == 7'd0) begin
          miso_d  = 1'b1;
          tx_d    = 8'hFC;
          cnt_d   = 7'd7;
          state_d = S_R_TOKEN;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_R_TOKEN: begin
        if (cnt_q != 7'd0) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b1};
          cnt_d  = cnt_q - 7'd1;
        end else begin
          miso_d  = sh_q[63];
          sh_d    = {sh_q[62:0], 1'b0};
          crc16_d = crc16_step(crc16_q, sh_q[63]);
          cnt_d   = 7'd79;
          state_d = S_R_DATA;
        end
      end
      S_R_DATA: begin
        // cnt counts bits still to send; above 16 they are data, else CRC
        if (cnt_q == 7'd0) begin
          miso_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (cnt_q > 7'd16) begin
            miso_d  = sh_q[63];
            sh_d    = {sh_q[62:0], 1'b0};
            crc16_d = crc16_step(crc16_q, sh_q[63]);
          end else begin
            miso_d  = crc16_q[15];
            crc16_d = {crc16_q[14:0], 1'b0};
          end
          cnt_d = cnt_q - 7'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      crc7_q   <= '0;
      crc16_q  <= '0;
      rx_crc_q <= '0;
      tx_q     <= '0;
      r1_q     <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      miso_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      crc7_q   <= crc7_d;
      crc16_q  <= crc16_d;
      rx_crc_q <= rx_crc_d;
      tx_q     <= tx_d;
      r1_q     <= r1_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      miso_q   <= miso_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign miso    = miso_q;
  assign busy    = (state_q != S_IDLE);
  assign last_r1 = r1_q;

endmodule
